counter_sequencer: RTL and testbench
====================================

// Module: counter_sequencer
// PURPOSE
//  - Command-driven controller for the up/down load counter. Sequences load_n/ce/up_down/data_load.
//  - Turns the counter into a one-shot or auto-reload timer: load a start value, count to terminal, report done.
//  - Sits between a host command port (valid/ready) and one counter instance sharing clk/rst_n.
// PARAMETERS
//  WIDTH   4  counter width; data_load/cmd_value width; must match the counter instance
//  WRAP_W  8  width of the reload-event counter wrap_count
// PORTS
//  clk         in   1       clock
//  rst_n       in   1       asynchronous active-low reset
//  cmd_valid   in   1       command present
//  cmd_ready   out  1       command accepted when cmd_valid && cmd_ready
//  cmd_op      in   2       00 START, 01 STOP, 10 PAUSE, 11 RESUME
//  cmd_value   in   WIDTH   start/reload value (START only)
//  cmd_up      in   1       1 = count up (terminal max_count), 0 = down (terminal zero)
//  cmd_reload  in   1       1 = auto-reload at terminal, 0 = one-shot
//  zero        in   1       from counter: count_out == 0
//  max_count   in   1       from counter: count_out == 2**WIDTH-1
//  load_n      out  1       to counter, active-low load
//  ce          out  1       to counter, count enable
//  up_down     out  1       to counter, direction
//  data_load   out  WIDTH   to counter, load value
//  busy        out  1       1 in LOAD, RUN, HOLD
//  done        out  1       one-cycle pulse on terminal cycle in RUN
//  wrap_count  out  WRAP_W  number of auto-reloads since last START, saturating
// BEHAVIOUR
//  - Reset (async): state IDLE; data_load=0, up_down=0, wrap_count=0; load_n=1, ce=0, done=0, busy=0, cmd_ready=1.
//  - States IDLE, LOAD, RUN, HOLD. cmd_ready = (state != LOAD).
//  - data_load, up_down, reload flag: registered, captured from cmd_* on accepted START; held otherwise.
//  - term = up_down ? max_count : zero (combinational).
//  - load_n = !(state==LOAD || (state==RUN && term && reload)); ce = (state==RUN) && !term; both combinational.
//  - done = (state==RUN) && term (combinational, one cycle per terminal).
//  - START (any state): -> LOAD; clears wrap_count. LOAD lasts exactly 1 cycle, then RUN.
//  - RUN: counter counts 1 per cycle. At term: reload=1 -> counter reloaded next edge, stay RUN, wrap_count+1
//    (saturates at 2**WRAP_W-1); reload=0 -> counter holds at terminal, state -> IDLE.
//  - Period: auto-reload down with value V gives done every V+1 cycles; up gives every 2**WIDTH-V cycles.
//  - STOP (RUN/HOLD): -> IDLE, counter holds. PAUSE (RUN): -> HOLD. RESUME (HOLD): -> RUN.
//  - Commands illegal for current state (STOP in IDLE, PAUSE outside RUN, RESUME outside HOLD): accepted, no effect.
//  - Command decode uses next-state only: a PAUSE/STOP accepted in RUN on a non-terminal cycle still lets
//    that cycle's count happen (ce from current state).
//  - Command coincident with term in RUN: terminal action (done, reload load_n, wrap_count) happens that cycle;
//    command then sets next state (START->LOAD, STOP->IDLE, PAUSE->HOLD; one-shot end overrides PAUSE/RESUME -> IDLE).
//  - Value at terminal (START V=0 down, V=2**WIDTH-1 up): first RUN cycle is terminal; done immediately.
//  - rst_n low mid-operation: immediate return to reset values; counter cleared by same reset.
// CONFIGURATION
//  - COUNTER_SEQ_WRAP_CNT_EN defined: wrap_count implemented as above.
//  - Not defined: wrap_count tied to 0; no counter register; all other behaviour unchanged.
// TESTING (WIDTH=4, WRAP_W=8, COUNTER_SEQ_WRAP_CNT_EN defined)
//  1 START down V=3 one-shot -> 1 LOAD cycle, count_out 3,2,1,0; done on 0 cycle; busy low after; count holds 0.
//  2 START down V=2 reload -> count_out 2,1,0,2,1,0,2; done every 3 cycles; wrap_count 1,2 after each reload.
//  3 START up V=13 one-shot -> count_out 13,14,15; done on 15; state IDLE; count holds 15.
//  4 START down V=9, PAUSE at count 6, wait 5 cycles, RESUME -> count 5 then holds 5 for 5 cycles, continues 4..0.
//  5 STOP coincident with term in reload mode -> done=1, counter reloaded, state IDLE, wrap_count=1.
//  6 rst_n low at count 4 of START down V=8 -> all outputs reset values, state IDLE, cmd_ready=1.

Source files
------------

// File: rtl/counter_sequencer_if.sv
// Host command port of the counter sequencer: valid/ready handshake plus the command payload.
interface counter_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_value;
  logic             cmd_up;
  logic             cmd_reload;

  modport master (
    output cmd_valid, cmd_op, cmd_value, cmd_up, cmd_reload,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_value, cmd_up, cmd_reload,
    output cmd_ready
  );
endinterface

// File: rtl/counter_sequencer.sv
// Command-driven sequencer that turns an up/down load counter into a one-shot or auto-reload timer.
// Define COUNTER_SEQ_WRAP_CNT_EN to build the saturating reload-event counter wrap_count.
//
// state | meaning
// IDLE  | waiting for START; counter holds
// LOAD  | counter loaded with captured start value (one cycle)
// RUN   | counting one step per cycle toward terminal
// HOLD  | paused; counter holds until RESUME
module counter_sequencer #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  counter_sequencer_if.slave   cmd,
  input  logic                 zero,
  input  logic                 max_count,
  output logic                 load_n,
  output logic                 ce,
  output logic                 up_down,
  output logic [WIDTH-1:0]     data_load,
  output logic                 busy,
  output logic                 done,
  output logic [WRAP_W-1:0]    wrap_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_STOP   = 2'b01;
  localparam logic [1:0] OP_PAUSE  = 2'b10;
  localparam logic [1:0] OP_RESUME = 2'b11;

  state_t state, state_nxt;
  logic   reload;
  logic   term;
  logic   accept;
  logic   start_acc;
  logic   oneshot_end;
  logic   reload_evt;

  assign accept      = cmd.cmd_valid && cmd.cmd_ready;
  assign start_acc   = accept && (cmd.cmd_op == OP_START);
  assign term        = up_down ? max_count : zero;
  assign oneshot_end = (state == RUN) && term && !reload;
  assign reload_evt  = (state == RUN) && term && reload;

  assign cmd.cmd_ready = (state != LOAD);
  assign busy          = (state != IDLE);
  assign done          = (state == RUN) && term;
  assign load_n        = !((state == LOAD) || reload_evt);
  assign ce            = (state == RUN) && !term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      data_load <= '0;
      up_down   <= 1'b0;
      reload    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        data_load <= cmd.cmd_value;
        up_down   <= cmd.cmd_up;
        reload    <= cmd.cmd_reload;
      end
    end
  end

  // Terminal handling first, then an accepted command overrides the next state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = IDLE;
      LOAD: state_nxt = RUN;
      RUN:  if (oneshot_end) state_nxt = IDLE;
      HOLD: state_nxt = HOLD;
      default: state_nxt = IDLE;
    endcase
    if (accept) begin
      unique case (cmd.cmd_op)
        OP_START:  state_nxt = LOAD;
        OP_STOP:   if (state == RUN || state == HOLD) state_nxt = IDLE;
        OP_PAUSE:  if (state == RUN && !oneshot_end) state_nxt = HOLD;
        OP_RESUME: if (state == HOLD) state_nxt = RUN;
        default:   state_nxt = state_nxt;
      endcase
    end
  end

`ifdef COUNTER_SEQ_WRAP_CNT_EN
  logic [WRAP_W-1:0] wrap_q;

  // START clears even when it coincides with a reload event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= '0;
    end else if (start_acc) begin
      wrap_q <= '0;
    end else if (reload_evt && (wrap_q != {WRAP_W{1'b1}})) begin
      wrap_q <= wrap_q + 1'b1;
    end
  end

  assign wrap_count = wrap_q;
`else
  assign wrap_count = '0;
`endif

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed timer scenarios plus random commands against a cycle-level reference.
module tb_counter_sequencer;

  localparam int W  = 4;
  localparam int WW = 8;
  localparam int MAXV = (1 << W) - 1;
  localparam int WMAX = (1 << WW) - 1;
`ifdef COUNTER_SEQ_WRAP_CNT_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_HOLD = 3;
  localparam int OP_START = 0, OP_STOP = 1, OP_PAUSE = 2, OP_RESUME = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  counter_sequencer_if #(.WIDTH(W)) cmd_if ();

  logic          zero, max_count, load_n, ce, up_down, busy, done;
  logic [W-1:0]  data_load;
  logic [WW-1:0] wrap_count;
  logic [W-1:0]  count_out;

  counter_sequencer #(.WIDTH(W), .WRAP_W(WW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cmd_if),
    .zero       (zero),
    .max_count  (max_count),
    .load_n     (load_n),
    .ce         (ce),
    .up_down    (up_down),
    .data_load  (data_load),
    .busy       (busy),
    .done       (done),
    .wrap_count (wrap_count)
  );

  // The up/down load counter the sequencer drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count_out <= '0;
    else if (!load_n) count_out <= data_load;
    else if (ce)      count_out <= up_down ? count_out + 1'b1 : count_out - 1'b1;
  end
  assign zero      = (count_out == '0);
  assign max_count = (count_out == '1);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: timer described by phase, integer count and captured command fields.
  int m_phase, m_cnt, m_val, m_wrap;
  bit m_up, m_rel;
  int cyc;
  int done_q[$];

  task automatic model_reset();
    m_phase = P_IDLE; m_cnt = 0; m_val = 0; m_wrap = 0; m_up = 0; m_rel = 0;
  endtask

  task automatic drive(input bit v, input int op, input int val, input bit up, input bit rel);
    cmd_if.cmd_valid  = v;
    cmd_if.cmd_op     = op[1:0];
    cmd_if.cmd_value  = val[W-1:0];
    cmd_if.cmd_up     = up;
    cmd_if.cmd_reload = rel;
  endtask

  // Called at a negedge with inputs already applied; checks this cycle, then advances the model.
  task automatic cycle();
    bit term, acc, oneshot_end;
    int nphase, ncnt;
    #1;
    term = m_up ? (m_cnt == MAXV) : (m_cnt == 0);
    check("count",     count_out,          m_cnt);
    check("done",      done,               (m_phase == P_RUN) && term);
    check("busy",      busy,               m_phase != P_IDLE);
    check("cmd_ready", cmd_if.cmd_ready,   m_phase != P_LOAD);
    check("ce",        ce,                 (m_phase == P_RUN) && !term);
    check("load_n",    load_n,             !((m_phase == P_LOAD) || (m_phase == P_RUN && term && m_rel)));
    check("data_load", data_load,          m_val);
    check("up_down",   up_down,            m_up);
    check("wrap",      wrap_count,         WRAP_EN ? m_wrap : 0);
    if (m_phase == P_RUN && term) done_q.push_back(cyc);

    acc = cmd_if.cmd_valid && (m_phase != P_LOAD);
    oneshot_end = (m_phase == P_RUN) && term && !m_rel;
    nphase = m_phase;
    ncnt = m_cnt;
    if (m_phase == P_LOAD) begin
      ncnt = m_val;
      nphase = P_RUN;
    end else if (m_phase == P_RUN) begin
      if (!term) ncnt = (m_cnt + (m_up ? 1 : MAXV)) % (MAXV + 1);
      else if (m_rel) begin
        ncnt = m_val;
        if (m_wrap < WMAX) m_wrap++;
      end else nphase = P_IDLE;
    end
    if (acc) begin
      case (int'(cmd_if.cmd_op))
        OP_START: begin
          nphase = P_LOAD;
          m_val = int'(cmd_if.cmd_value);
          m_up = cmd_if.cmd_up;
          m_rel = cmd_if.cmd_reload;
          m_wrap = 0;
        end
        OP_STOP:   if (m_phase == P_RUN || m_phase == P_HOLD) nphase = P_IDLE;
        OP_PAUSE:  if (m_phase == P_RUN && !oneshot_end) nphase = P_HOLD;
        default:   if (m_phase == P_HOLD) nphase = P_RUN;
      endcase
    end
    m_phase = nphase;
    m_cnt = ncnt;
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input int op, input int val, input bit up, input bit rel);
    drive(1'b1, op, val, up, rel);
    cycle();
    drive(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_count",  count_out,        0);
    check("rst_busy",   busy,             0);
    check("rst_done",   done,             0);
    check("rst_ready",  cmd_if.cmd_ready, 1);
    check("rst_load_n", load_n,           1);
    check("rst_ce",     ce,               0);
    check("rst_data",   data_load,        0);
    check("rst_updown", up_down,          0);
    check("rst_wrap",   wrap_count,       0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc++;
  endtask

  // Reload period from the timing rule: down V -> V+1 cycles, up V -> 2**W-V cycles.
  task automatic check_period(input string tag, input int val, input bit up);
    int exp_p;
    exp_p = up ? (MAXV + 1 - val) : (val + 1);
    check({tag, "_pulses"}, (done_q.size() >= 3), 1);
    for (int i = 1; i < done_q.size(); i++)
      check(tag, done_q[i] - done_q[i-1], exp_p);
  endtask

  initial begin
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    model_reset();
    cyc = 0;
    #2;
    do_reset();

    // down one-shot V=3
    send(OP_START, 3, 0, 0);
    idle(7);
    // down reload V=2, periodic done
    send(OP_START, 2, 0, 1);
    done_q.delete();
    idle(12);
    check_period("period_dn2", 2, 0);
    send(OP_STOP, 0, 0, 0);
    // up one-shot V=13
    send(OP_START, 13, 1, 0);
    idle(6);
    // up reload V=10
    send(OP_START, 10, 1, 1);
    done_q.delete();
    idle(20);
    check_period("period_up10", 10, 1);
    // down V=9, PAUSE while count shows 6, hold 5 cycles, RESUME
    send(OP_START, 9, 0, 0);
    idle(4);
    check("pause_at", count_out, 6);
    send(OP_PAUSE, 0, 0, 0);
    idle(5);
    check("held", count_out, 5);
    send(OP_RESUME, 0, 0, 0);
    idle(8);
    // STOP coincident with terminal in reload mode
    send(OP_START, 2, 0, 1);
    idle(3);
    check("stop_term_cnt", count_out, 0);
    send(OP_STOP, 0, 0, 0);
    idle(2);
    check("stop_term_wrap", wrap_count, WRAP_EN ? 1 : 0);
    // value already at terminal, then wrap saturation with V=0 reload
    send(OP_START, 0, 0, 0);
    idle(3);
    send(OP_START, 15, 1, 0);
    idle(3);
    send(OP_START, 0, 0, 1);
    idle(262);
    check("wrap_sat", wrap_count, WRAP_EN ? WMAX : 0);
    send(OP_STOP, 0, 0, 0);
    // illegal commands in IDLE
    send(OP_STOP, 0, 0, 0);
    send(OP_PAUSE, 0, 0, 0);
    send(OP_RESUME, 0, 0, 0);
    // reset at count 4 of down V=8
    send(OP_START, 8, 0, 0);
    idle(5);
    check("pre_reset_cnt", count_out, 4);
    do_reset();
    idle(2);

    // random command streams
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, MAXV),
              $urandom_range(0, 1), $urandom_range(0, 1));
        cycle();
      end
    end
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
